// File: rtl/io_ctrl.sv
// Memory-mapped I/O controller: latches the switches as two operands on BTNR,
// accepts a CPU result and scans it onto the 8-digit seven-segment display.
module io_ctrl #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int SCAN_DIV        = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pRead,
    input  logic        pWrite,
    input  logic [7:0]  addr,
    input  logic [31:0] pWriteData,
    output logic [31:0] pReadData,
    input  logic        BTNL,
    input  logic        BTNR,
    input  logic [15:0] SW,
    output logic [7:0]  AN,
    output logic        DP,
    output logic [6:0]  A2G
);

    localparam int DB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    // Button lanes: index 0 is BTNR, index 1 is BTNL.
    logic [1:0]      btn_s1;
    logic [1:0]      btn_s2;
    logic [1:0]      db_level;
    logic [1:0]      db_prev;
    logic [DB_W-1:0] db_cnt [2];
    logic [1:0]      rise;

    logic [15:0]       sw_s1;
    logic [15:0]       sw_s2;
    logic [15:0]       sw_latch;
    logic              input_ready;
    logic              output_ready;
    logic [31:0]       disp_reg;
    logic [SCAN_W-1:0] scan_cnt;
    logic [2:0]        digit;

    logic read_opb;
    logic write_disp;
    logic unused_addr_bits;

    assign read_opb         = pRead  && (addr[3:2] == 2'd2);
    assign write_disp       = pWrite && (addr[3:2] == 2'd3);
    assign unused_addr_bits = ^{addr[7:4], addr[1:0]};
    assign rise             = db_level & ~db_prev;

    always_ff @(posedge clk) begin
        if (reset) begin
            btn_s1   <= '0;
            btn_s2   <= '0;
            db_level <= '0;
            db_prev  <= '0;
            sw_s1    <= '0;
            sw_s2    <= '0;
            for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
        end else begin
            btn_s1  <= {BTNL, BTNR};
            btn_s2  <= btn_s1;
            db_prev <= db_level;
            sw_s1   <= SW;
            sw_s2   <= sw_s1;
            // The counter only runs while the synchronized level disagrees with
            // the accepted one; any agreeing sample restarts the qualification.
            for (int i = 0; i < 2; i++) begin
                if (btn_s2[i] == db_level[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                    db_cnt[i]   <= '0;
                    db_level[i] <= btn_s2[i];
                end else begin
                    db_cnt[i] <= db_cnt[i] + DB_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sw_latch     <= '0;
            input_ready  <= 1'b0;
            output_ready <= 1'b1;
            disp_reg     <= '0;
        end else begin
            // Fresh operands win over a concurrent OPB read.
            if (rise[0]) begin
                sw_latch    <= sw_s2;
                input_ready <= 1'b1;
            end else if (read_opb) begin
                input_ready <= 1'b0;
            end
            // A new result wins over a concurrent acknowledge.
            if (write_disp) begin
                disp_reg     <= pWriteData;
                output_ready <= 1'b0;
            end else if (rise[1]) begin
                output_ready <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            scan_cnt <= '0;
            digit    <= '0;
        end else if (scan_cnt == SCAN_W'(SCAN_DIV - 1)) begin
            scan_cnt <= '0;
            digit    <= digit + 3'd1;
        end else begin
            scan_cnt <= scan_cnt + SCAN_W'(1);
        end
    end

    always_comb begin
        pReadData = '0;
        case (addr[3:2])
            2'd0: pReadData = {30'b0, input_ready, output_ready};
            2'd1: pReadData = {24'b0, sw_latch[15:8]};
            2'd2: pReadData = {24'b0, sw_latch[7:0]};
            2'd3: pReadData = disp_reg;
            default: pReadData = '0;
        endcase
    end

    function automatic logic [6:0] seg_font(input logic [3:0] value);
        logic [6:0] seg;
        case (value)
            4'h0: seg = 7'b0000001;
            4'h1: seg = 7'b1001111;
            4'h2: seg = 7'b0010010;
            4'h3: seg = 7'b0000110;
            4'h4: seg = 7'b1001100;
            4'h5: seg = 7'b0100100;
            4'h6: seg = 7'b0100000;
            4'h7: seg = 7'b0001111;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0000100;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b1100000;
            4'hC: seg = 7'b0110001;
            4'hD: seg = 7'b1000010;
            4'hE: seg = 7'b0110000;
            default: seg = 7'b0111000;
        endcase
        return seg;
    endfunction

    assign AN  = ~(8'b0000_0001 << digit);
    assign A2G = seg_font(disp_reg[{digit, 2'b00} +: 4]);
    assign DP  = 1'b1;

endmodule

// File: doc/io_ctrl.md
# io_ctrl

Memory-mapped I/O controller between the multicycle MIPS datapath and the board peripherals. It latches the 16 switches as two 8-bit operands when BTNR is pressed and exposes them through status/data registers. It accepts a 32-bit result written by the CPU and time-multiplexes it as 8 hex digits on the seven-segment display. It sits directly below `top`, beside data memory, and drives `AN`/`DP`/`A2G` for the board.

## Interface
- `DEBOUNCE_CYCLES`, 4: consecutive equal synchronized samples required before a button level is accepted. Board builds use 1_000_000.
- `SCAN_DIV`, 8: clock cycles per display digit. Board builds use 100_000.
- `clk` in 1: single clock. All state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `pRead` in 1: CPU read strobe, already qualified by the upstream I/O address decode.
- `pWrite` in 1: CPU write strobe, qualified the same way.
- `addr` in 8: byte address within the I/O window. Only `addr[3:2]` is decoded.
- `pWriteData` in 32: CPU store data.
- `pReadData` out 32: load data, combinational from `addr` and register state.
- `BTNL` in 1: asynchronous button that acknowledges the displayed result.
- `BTNR` in 1: asynchronous button that latches the switches.
- `SW` in 16: asynchronous switches. `SW[15:8]` is operand A, `SW[7:0]` is operand B.
- `AN` out 8: digit enables, active-low, one-hot.
- `DP` out 1: decimal point, active-low. Tied to 1 (off).
- `A2G` out 7: segments, active-low. `A2G[6]`=a … `A2G[0]`=g.

## Operation
- **Register map (`addr[3:2]`):**
  - 0: STATUS, read-only. `{30'b0, input_ready, output_ready}`.
  - 1: OPA, read-only. `{24'b0, sw_latch[15:8]}`.
  - 2: OPB, read-only. `{24'b0, sw_latch[7:0]}`. A read clears `input_ready`.
  - 3: DISP, read/write. The 32-bit display register.
- Writes to addresses 0–2 are ignored.
- **Buttons:**
  - Each button passes through a 2-flop synchronizer, then a debouncer.
  - The debouncer holds a counter. The debounced level takes the synchronized value after `DEBOUNCE_CYCLES` consecutive equal samples; any mismatch reloads the counter.
  - A rise event is a one-cycle pulse on a debounced 0→1 transition. A button held high produces exactly one event.
- **BTNR rise:** load `sw_latch <= SW` (the SW value sampled through its own 2-flop synchronizer) and set `input_ready`.
- **BTNL rise:** set `output_ready`.
- **Write to DISP:** load `disp_reg <= pWriteData` and clear `output_ready`.
- **Simultaneous events:**
  - BTNR rise in the same cycle as an OPB read: set wins (the new data is unread).
  - BTNL rise in the same cycle as a DISP write: the write wins (`output_ready` = 0).
- **Scanner:**
  - `scan_cnt` counts 0..`SCAN_DIV`-1. On wrap, `digit` increments mod 8 (7→0).
  - `AN` = ~(1 << `digit`).
  - `A2G` = font(`disp_reg[4*digit+3 : 4*digit]`), combinational from registered `digit` and `disp_reg`.
- **Font (a..g, active-low):**
  - 0:0000001, 1:1001111, 2:0010010, 3:0000110
  - 4:1001100, 5:0100100, 6:0100000, 7:0001111
  - 8:0000000, 9:0000100, A:0001000, b:1100000
  - C:0110001, d:1000010, E:0110000, F:0111000

## Timing
- **Reset values:**
  - Registers: `input_ready`=0, `output_ready`=1, `sw_latch`=0, `disp_reg`=0, `digit`=0, `scan_cnt`=0, all synchronizer and debounce state 0.
  - Outputs: `AN`=8'b1111_1110, `A2G`=7'b0000001, `DP`=1.
- **Button latency:** `input_ready`/`output_ready` becomes 1 exactly `DEBOUNCE_CYCLES`+3 rising edges after the first edge that samples the button high (2 synchronizer stages, `DEBOUNCE_CYCLES` to accept the level, 1 for the flag). The level must stay stable throughout.
- **Reads:** `pReadData` is valid in the same cycle as `addr`. The OPB-read clear takes effect at the edge ending that cycle, so a CPU holding `pRead` for several cycles sees the same data each cycle.
- **DISP write:** the new value is visible on `A2G` the cycle after the write edge.
- **Digit dwell:** each digit is enabled for exactly `SCAN_DIV` cycles. A full frame is 8·`SCAN_DIV` cycles.
- **Reset mid-operation:** reset asserted for one edge returns every register to its reset value, including a half-counted debouncer. A button still held afterwards re-qualifies and produces a new event.

## Test plan
- **Operand latch:** reset 1 cycle, SW=16'h0408, BTNR=1 → STATUS=32'h3 after 7 edges (DEBOUNCE_CYCLES=4). Then:
  - OPA read → 32'h4.
  - OPB read → 32'h8.
  - Next STATUS read → 32'h1.
- **Held button:** BTNR and BTNL held at 1 for 200 cycles → exactly one rise event each. After an OPB read, `input_ready` stays 0.
- **Display write:** write DISP=32'h0000000C → STATUS bit0=0. With `digit`=0: `AN`=8'hFE, `A2G`=7'b0110001. Then BTNL pulse → bit0=1 after 7 edges.
- **Scan wrap:** DISP=32'h89ABCDEF, observe 64 cycles → `AN` steps FE, FD, …, 7F, back to FE. Digit 7 shows 8 (7'b0000000). Each `AN` value lasts 8 cycles.
- **Simultaneous events:**
  - OPB read in the same cycle as the BTNR rise pulse → `input_ready`=1.
  - DISP write in the same cycle as the BTNL rise pulse → `output_ready`=0.
- **Reset mid-operation:** reset asserted during debounce counting and mid-frame → outputs equal the reset values on the next cycle. A held BTNR sets `input_ready` 7 edges after reset deasserts.
